// File: rtl/rsa256_uart_wrapper.sv
// rsa256_uart_wrapper: Avalon-MM master that loads N, d and ciphertext from a
// UART, runs the RSA-256 core and streams the 31-byte plaintext back out.
module rsa256_uart_wrapper #(
    parameter int RX_BASE     = 0,
    parameter int TX_BASE     = 4,
    parameter int STATUS_BASE = 8,
    parameter int RX_OK_BIT   = 7,
    parameter int TX_OK_BIT   = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_rsa_start,
    output logic [255:0] o_rsa_a,
    output logic [255:0] o_rsa_d,
    output logic [255:0] o_rsa_n,
    input  logic [255:0] i_rsa_a_pow_d,
    input  logic         i_rsa_finished
);

    typedef enum logic [2:0] {
        S_QUERY_RX,
        S_READ,
        S_START,
        S_WAIT,
        S_QUERY_TX,
        S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        PH_N,
        PH_D,
        PH_A
    } phase_t;

    localparam logic [4:0] ADDR_RX = 5'(RX_BASE);
    localparam logic [4:0] ADDR_TX = 5'(TX_BASE);
    localparam logic [4:0] ADDR_ST = 5'(STATUS_BASE);

    state_t       state;
    phase_t       phase;
    logic [255:0] n_r;
    logic [255:0] d_r;
    logic [255:0] a_r;
    logic [255:0] dec_r;
    logic [5:0]   bytes_cnt;
    logic         rd_done;
    logic         wr_done;
    logic [7:0]   rx_byte;
    logic         unused_rd;

    assign rd_done   = avm_read & ~avm_waitrequest;
    assign wr_done   = avm_write & ~avm_waitrequest;
    assign rx_byte   = avm_readdata[7:0];
    assign unused_rd = ^avm_readdata[31:8];

    assign o_rsa_n = n_r;
    assign o_rsa_d = d_r;
    assign o_rsa_a = a_r;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_QUERY_RX;
            phase         <= PH_N;
            n_r           <= '0;
            d_r           <= '0;
            a_r           <= '0;
            dec_r         <= '0;
            bytes_cnt     <= '0;
            avm_address   <= ADDR_ST;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            o_rsa_start   <= 1'b0;
        end else begin
            unique case (state)
                S_QUERY_RX: begin
                    // A failed poll leaves the request up, re-issuing it
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_ST;
                    end else if (rd_done && avm_readdata[RX_OK_BIT]) begin
                        avm_address <= ADDR_RX;
                        state       <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_done) begin
                        unique case (phase)
                            PH_N:    n_r <= {n_r[247:0], rx_byte};
                            PH_D:    d_r <= {d_r[247:0], rx_byte};
                            default: a_r <= {a_r[247:0], rx_byte};
                        endcase
                        avm_address <= ADDR_ST;
                        if (bytes_cnt == 6'd31) begin
                            bytes_cnt <= '0;
                            unique case (phase)
                                PH_N: begin
                                    phase <= PH_D;
                                    state <= S_QUERY_RX;
                                end
                                PH_D: begin
                                    phase <= PH_A;
                                    state <= S_QUERY_RX;
                                end
                                default: begin
                                    avm_read    <= 1'b0;
                                    o_rsa_start <= 1'b1;
                                    state       <= S_START;
                                end
                            endcase
                        end else begin
                            bytes_cnt <= bytes_cnt + 6'd1;
                            state     <= S_QUERY_RX;
                        end
                    end
                end
                S_START: begin
                    o_rsa_start <= 1'b0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_rsa_finished) begin
                        dec_r       <= i_rsa_a_pow_d;
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_ST;
                        state       <= S_QUERY_TX;
                    end
                end
                S_QUERY_TX: begin
                    if (rd_done && avm_readdata[TX_OK_BIT]) begin
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b1;
                        avm_address   <= ADDR_TX;
                        avm_writedata <= {24'b0, dec_r[247:240]};
                        state         <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_done) begin
                        avm_write   <= 1'b0;
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_ST;
                        dec_r       <= dec_r << 8;
                        if (bytes_cnt == 6'd30) begin
                            bytes_cnt <= '0;
                            phase     <= PH_A;
                            state     <= S_QUERY_RX;
                        end else begin
                            bytes_cnt <= bytes_cnt + 6'd1;
                            state     <= S_QUERY_TX;
                        end
                    end
                end
                default: state <= S_QUERY_RX;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa256_uart_wrapper.sv
// Directed bench for rsa256_uart_wrapper: UART slave and RSA core models
// sampled on the falling edge, scenario tasks run in sequence.
module tb_rsa256_uart_wrapper;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest;
    logic         o_rsa_start;
    logic [255:0] o_rsa_a;
    logic [255:0] o_rsa_d;
    logic [255:0] o_rsa_n;
    logic [255:0] i_rsa_a_pow_d;
    logic         i_rsa_finished;

    logic         model_en = 1'b0;
    logic [31:0]  r_rdata = '0;
    logic         r_wait = 1'b0;
    logic         r_fin = 1'b0;
    logic [255:0] r_apowd = '0;
    logic [31:0]  m_rdata = '0;
    logic         m_wait = 1'b0;
    logic         m_fin = 1'b0;
    logic [255:0] m_apowd = '0;

    logic [7:0]   rx_mem [0:511];
    logic [7:0]   wr_mem [0:127];
    int           rx_wr = 0;
    int           rx_hold_n = 5;
    int           stall_at = 31;
    int           stall_n = 4;
    int           tx_hold_at = -1;
    int           tx_hold_n = 0;
    logic [255:0] core_result = 256'h10;

    int rd_ptr = 0, rd_since_rst = 0, wr_cnt = 0;
    int rx_hold_used = 0, stall_used = 0, tx_hold_used = 0;
    int bad_read = 0, bad_write = 0, wr_bad = 0, rw_bad = 0;
    int stall_bad = 0, lat_bad = 0, start_bad = 0;
    int start_cnt = 0, last_start_reads = 0, core_cnt = 0;
    logic in_stall = 1'b0, exp_start = 1'b0;
    logic fin_prev = 1'b0, start_prev = 1'b0;
    logic [255:0] stall_snap = '0;

    int checks = 0;
    int errors = 0;

    assign avm_readdata    = model_en ? m_rdata : r_rdata;
    assign avm_waitrequest = model_en ? m_wait : r_wait;
    assign i_rsa_finished  = model_en ? m_fin : r_fin;
    assign i_rsa_a_pow_d   = model_en ? m_apowd : r_apowd;

    always #5 clk = ~clk;

    rsa256_uart_wrapper dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .o_rsa_start     (o_rsa_start),
        .o_rsa_a         (o_rsa_a),
        .o_rsa_d         (o_rsa_d),
        .o_rsa_n         (o_rsa_n),
        .i_rsa_a_pow_d   (i_rsa_a_pow_d),
        .i_rsa_finished  (i_rsa_finished)
    );

    // UART slave and core model; inputs change only on the falling edge
    always @(negedge clk) begin : model
        logic rx_ok;
        logic tx_ok;
        if (!model_en || rst) begin
            m_wait = 1'b0;
            m_rdata = '0;
            m_fin = 1'b0;
            rd_since_rst = 0;
            core_cnt = 0;
            in_stall = 1'b0;
            exp_start = 1'b0;
            fin_prev = 1'b0;
            start_prev = 1'b0;
        end else begin
            if (exp_start) begin
                if (!o_rsa_start) lat_bad++;
                exp_start = 1'b0;
            end
            if (fin_prev) begin
                if (!(avm_read && avm_address == 5'd8)) lat_bad++;
                fin_prev = 1'b0;
            end
            if (in_stall) begin
                if (!(avm_read && !avm_write && avm_address == 5'd0) ||
                    o_rsa_n !== stall_snap) stall_bad++;
                in_stall = 1'b0;
            end
            if (o_rsa_start) begin
                if (start_prev) start_bad++;
                start_cnt++;
                last_start_reads = rd_since_rst;
                core_cnt = 200;
            end
            start_prev = o_rsa_start;
            m_fin = 1'b0;
            for (int i = 0; i < 8; i++) m_apowd[i*32 +: 32] = $urandom;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    m_fin = 1'b1;
                    m_apowd = core_result;
                    fin_prev = 1'b1;
                end
            end
            m_wait = 1'b0;
            m_rdata = $urandom;
            if (avm_read && avm_write) rw_bad++;
            if (avm_write) begin
                if (tx_hold_used < tx_hold_n && wr_cnt == tx_hold_at) bad_write++;
                if (avm_address != 5'd4 || avm_writedata[31:8] != 24'd0) wr_bad++;
                if (wr_cnt < 128) wr_mem[wr_cnt] = avm_writedata[7:0];
                wr_cnt++;
            end else if (avm_read) begin
                if (avm_address == 5'd8) begin
                    rx_ok = 1'b0;
                    tx_ok = 1'b1;
                    if (rx_hold_used < rx_hold_n) begin
                        rx_hold_used++;
                        tx_ok = 1'b0;
                    end else begin
                        rx_ok = (rd_ptr < rx_wr);
                    end
                    if (tx_hold_used < tx_hold_n && wr_cnt == tx_hold_at) begin
                        tx_ok = 1'b0;
                        tx_hold_used++;
                    end
                    m_rdata[7] = rx_ok;
                    m_rdata[6] = tx_ok;
                end else if (avm_address == 5'd0) begin
                    if (rx_hold_used < rx_hold_n || rd_ptr >= rx_wr) bad_read++;
                    m_rdata[7:0] = rx_mem[rd_ptr];
                    if (rd_ptr == stall_at && stall_used < stall_n) begin
                        m_wait = 1'b1;
                        stall_used++;
                        in_stall = 1'b1;
                        if (stall_used == 1) stall_snap = o_rsa_n;
                    end else begin
                        rd_ptr++;
                        rd_since_rst++;
                        if (rd_since_rst >= 96 && (rd_since_rst % 32) == 0)
                            exp_start = 1'b1;
                    end
                end else begin
                    bad_read++;
                end
            end
        end
    end

    task automatic push_block(input logic [7:0] last);
        for (int i = 0; i < 31; i++) begin
            rx_mem[rx_wr] = 8'h00;
            rx_wr++;
        end
        rx_mem[rx_wr] = last;
        rx_wr++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        model_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            r_rdata = $urandom;
            r_wait = 1'($urandom);
            r_fin = 1'($urandom);
            for (int i = 0; i < 8; i++) r_apowd[i*32 +: 32] = $urandom;
        end
        checks++;
        if (avm_read !== 1'b0) begin
            errors++; $display("FAIL rst_read got %b exp 0", avm_read);
        end
        checks++;
        if (avm_write !== 1'b0) begin
            errors++; $display("FAIL rst_write got %b exp 0", avm_write);
        end
        checks++;
        if (avm_address !== 5'd8) begin
            errors++; $display("FAIL rst_addr got %0d exp 8", avm_address);
        end
        checks++;
        if (avm_writedata !== 32'd0) begin
            errors++; $display("FAIL rst_wdata got %0h exp 0", avm_writedata);
        end
        checks++;
        if (o_rsa_start !== 1'b0) begin
            errors++; $display("FAIL rst_start got %b exp 0", o_rsa_start);
        end
        checks++;
        if ((o_rsa_a | o_rsa_d | o_rsa_n) !== 256'd0) begin
            errors++; $display("FAIL rst_key got %0h exp 0", o_rsa_a | o_rsa_d | o_rsa_n);
        end
        model_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (avm_read !== 1'b1 || avm_address !== 5'd8) begin
            errors++;
            $display("FAIL rst_first_read got rd=%b addr=%0d exp rd=1 addr=8",
                     avm_read, avm_address);
        end
    endtask

    task automatic test_end_to_end;
        push_block(8'h21);
        push_block(8'h07);
        push_block(8'h04);
        for (int i = 0; i < 3000 && wr_cnt < 31; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (4) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (o_rsa_n !== 256'd33) begin
            errors++; $display("FAIL e2e_n got %0h exp 21", o_rsa_n);
        end
        checks++;
        if (o_rsa_d !== 256'd7) begin
            errors++; $display("FAIL e2e_d got %0h exp 7", o_rsa_d);
        end
        checks++;
        if (o_rsa_a !== 256'd4) begin
            errors++; $display("FAIL e2e_a got %0h exp 4", o_rsa_a);
        end
        checks++;
        if (start_cnt != 1 || start_bad != 0) begin
            errors++; $display("FAIL e2e_start got %0d (bad %0d) exp 1", start_cnt, start_bad);
        end
        checks++;
        if (last_start_reads != 96) begin
            errors++; $display("FAIL e2e_start_reads got %0d exp 96", last_start_reads);
        end
        checks++;
        if (wr_cnt != 31) begin
            errors++; $display("FAIL e2e_wr_cnt got %0d exp 31", wr_cnt);
        end
        begin
            int bad_idx;
            bad_idx = -1;
            for (int k = 0; k < 30; k++)
                if (bad_idx < 0 && wr_mem[k] !== 8'h00) bad_idx = k;
            checks++;
            if (bad_idx >= 0) begin
                errors++;
                $display("FAIL e2e_wr_zero got %0h at %0d exp 0", wr_mem[bad_idx], bad_idx);
            end
        end
        checks++;
        if (wr_mem[30] !== 8'h10) begin
            errors++; $display("FAIL e2e_wr_last got %0h exp 10", wr_mem[30]);
        end
        checks++;
        if (wr_bad != 0 || rw_bad != 0) begin
            errors++; $display("FAIL e2e_bus got wr_bad=%0d rw_bad=%0d exp 0", wr_bad, rw_bad);
        end
        checks++;
        if (lat_bad != 0) begin
            errors++; $display("FAIL e2e_latency got %0d exp 0", lat_bad);
        end
    endtask

    task automatic test_rx_poll_stall;
        checks++;
        if (rx_hold_used != 5) begin
            errors++; $display("FAIL rx_polls got %0d exp 5", rx_hold_used);
        end
        checks++;
        if (bad_read != 0) begin
            errors++; $display("FAIL rx_bad_read got %0d exp 0", bad_read);
        end
        checks++;
        if (stall_used != 4) begin
            errors++; $display("FAIL rx_stall_cycles got %0d exp 4", stall_used);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++; $display("FAIL rx_stall_hold got %0d exp 0", stall_bad);
        end
    endtask

    task automatic test_second_block;
        int base;
        int rd0;
        base = wr_cnt;
        rd0 = rd_ptr;
        core_result = 256'h1A;
        push_block(8'h05);
        for (int i = 0; i < 3000 && wr_cnt < base + 31; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (4) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (rd_ptr - rd0 != 32) begin
            errors++; $display("FAIL blk2_rx_bytes got %0d exp 32", rd_ptr - rd0);
        end
        checks++;
        if (o_rsa_n !== 256'd33 || o_rsa_d !== 256'd7) begin
            errors++; $display("FAIL blk2_key got n=%0h d=%0h exp n=21 d=7", o_rsa_n, o_rsa_d);
        end
        checks++;
        if (o_rsa_a !== 256'd5) begin
            errors++; $display("FAIL blk2_a got %0h exp 5", o_rsa_a);
        end
        checks++;
        if (start_cnt != 2) begin
            errors++; $display("FAIL blk2_start got %0d exp 2", start_cnt);
        end
        checks++;
        if (wr_cnt != base + 31) begin
            errors++; $display("FAIL blk2_wr_cnt got %0d exp %0d", wr_cnt, base + 31);
        end
        checks++;
        if (wr_mem[base + 30] !== 8'h1A) begin
            errors++; $display("FAIL blk2_wr_last got %0h exp 1a", wr_mem[base + 30]);
        end
    endtask

    task automatic test_tx_backpressure;
        int base;
        int bad_idx;
        base = wr_cnt;
        core_result = '0;
        for (int k = 0; k < 31; k++) core_result = {core_result[247:0], 8'(k + 1)};
        core_result[255:248] = 8'hFF;
        tx_hold_at = base + 6;
        tx_hold_n = 10;
        push_block(8'h09);
        for (int i = 0; i < 3000 && wr_cnt < base + 31; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (4) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (tx_hold_used != 10) begin
            errors++; $display("FAIL tx_polls got %0d exp 10", tx_hold_used);
        end
        checks++;
        if (bad_write != 0) begin
            errors++; $display("FAIL tx_write_blocked got %0d exp 0", bad_write);
        end
        checks++;
        if (wr_cnt != base + 31) begin
            errors++; $display("FAIL tx_wr_cnt got %0d exp %0d", wr_cnt, base + 31);
        end
        bad_idx = -1;
        for (int k = 0; k < 31; k++)
            if (bad_idx < 0 && wr_mem[base + k] !== 8'(k + 1)) bad_idx = k;
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("FAIL tx_order got %0h at %0d exp %0h",
                     wr_mem[base + bad_idx], bad_idx, bad_idx + 1);
        end
        checks++;
        if (o_rsa_a !== 256'd9 || start_cnt != 3) begin
            errors++; $display("FAIL tx_block got a=%0h starts=%0d exp a=9 starts=3",
                               o_rsa_a, start_cnt);
        end
        checks++;
        if (lat_bad != 0 || wr_bad != 0) begin
            errors++; $display("FAIL tx_bus got lat=%0d wr_bad=%0d exp 0", lat_bad, wr_bad);
        end
    endtask

    task automatic test_midload_reset;
        logic [255:0] exp_n;
        logic [7:0]   b;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        push_block(8'h33);
        for (int i = 0; i < 10; i++) begin
            rx_mem[rx_wr] = 8'h5A;
            rx_wr++;
        end
        for (int i = 0; i < 2000 && rd_since_rst < 42; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (o_rsa_n !== 256'h33) begin
            errors++; $display("FAIL mid_first_n got %0h exp 33", o_rsa_n);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (o_rsa_n !== 256'd0 || o_rsa_d !== 256'd0 || avm_read !== 1'b0) begin
            errors++; $display("FAIL mid_reset got n=%0h d=%0h rd=%b exp 0", o_rsa_n, o_rsa_d, avm_read);
        end
        rst = 1'b0;
        exp_n = '0;
        for (int i = 0; i < 32; i++) begin
            b = 8'hA0 + 8'(i);
            rx_mem[rx_wr] = b;
            rx_wr++;
            exp_n = {exp_n[247:0], b};
        end
        for (int i = 0; i < 2000 && rd_since_rst < 32; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (5) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (o_rsa_n !== exp_n) begin
            errors++; $display("FAIL mid_reload_n got %0h exp %0h", o_rsa_n, exp_n);
        end
        checks++;
        if (o_rsa_d !== 256'd0 || start_cnt != 3) begin
            errors++; $display("FAIL mid_no_start got d=%0h starts=%0d exp d=0 starts=3",
                               o_rsa_d, start_cnt);
        end
        push_block(8'h03);
        push_block(8'h02);
        for (int i = 0; i < 2000 && start_cnt < 4; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (start_cnt != 4 || last_start_reads != 96) begin
            errors++; $display("FAIL mid_start got starts=%0d reads=%0d exp starts=4 reads=96",
                               start_cnt, last_start_reads);
        end
        checks++;
        if (o_rsa_d !== 256'd3 || o_rsa_a !== 256'd2 || o_rsa_n !== exp_n) begin
            errors++; $display("FAIL mid_key got d=%0h a=%0h exp d=3 a=2", o_rsa_d, o_rsa_a);
        end
        checks++;
        if (lat_bad != 0 || bad_read != 0) begin
            errors++; $display("FAIL mid_bus got lat=%0d bad_read=%0d exp 0", lat_bad, bad_read);
        end
    endtask

    initial begin
        test_reset;
        test_end_to_end;
        test_rx_poll_stall;
        test_second_block;
        test_tx_backpressure;
        test_midload_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa256_uart_wrapper.md
# rsa256_uart_wrapper

Avalon-MM master that connects the RSA-256 decryption core to an RS-232 UART slave. It polls the UART for received bytes and assembles the 256-bit modulus N, private exponent d and ciphertext. It then starts the core, waits for completion, and streams the 31-byte plaintext back through the UART. The key is loaded once per reset; ciphertext blocks are then processed back-to-back indefinitely.

## Interface
Parameters:
- RX_BASE, 0, UART receive-data register address
- TX_BASE, 4, UART transmit-data register address
- STATUS_BASE, 8, UART status register address
- RX_OK_BIT, 7, status bit set when a received byte is available
- TX_OK_BIT, 6, status bit set when the transmitter can accept a byte

Ports:
- i_clk  in  1  single clock
- i_rst  in  1  reset, synchronous, active-high
- avm_address  out  5  Avalon address
- avm_read  out  1  Avalon read request
- avm_readdata  in  32  Avalon read data; only [7:0] used except for status bits
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  Avalon write data; [31:8] always 0
- avm_waitrequest  in  1  slave stall
- o_rsa_start  out  1  one-cycle start pulse to core
- o_rsa_a  out  256  ciphertext to core
- o_rsa_d  out  256  private exponent to core
- o_rsa_n  out  256  modulus to core
- i_rsa_a_pow_d  in  256  core result
- i_rsa_finished  in  1  core done pulse

## Operation
- All Avalon outputs and o_rsa_start are registered.
- Internal state:
  - n_r, d_r, a_r, each 256 bits, driving o_rsa_n/o_rsa_d/o_rsa_a directly
  - dec_r, 256 bits
  - bytes_cnt, 6 bits
  - phase ∈ {N, D, A}
- FSM states:
  - S_QUERY_RX: read STATUS_BASE. On the completion cycle (avm_waitrequest=0): readdata[RX_OK_BIT]=1 → S_READ; else re-issue the query.
  - S_READ: read RX_BASE. On completion, shift the target register left by 8 and load readdata[7:0] into the LSBs (first byte received = MSB), then bytes_cnt+1.
    - bytes_cnt reaches 32 in phase N → phase D, cnt=0, S_QUERY_RX.
    - bytes_cnt reaches 32 in phase D → phase A, cnt=0, S_QUERY_RX.
    - bytes_cnt reaches 32 in phase A → cnt=0, S_START.
    - Otherwise → S_QUERY_RX.
  - S_START: o_rsa_start=1 for exactly one cycle → S_WAIT.
  - S_WAIT: Avalon idle. When i_rsa_finished=1, latch dec_r ← i_rsa_a_pow_d → S_QUERY_TX.
  - S_QUERY_TX: read STATUS_BASE. On completion, readdata[TX_OK_BIT]=1 → S_WRITE; else re-query.
  - S_WRITE: write TX_BASE with writedata={24'b0, dec_r[247:240]}. On completion, dec_r ← dec_r<<8, bytes_cnt+1.
    - bytes_cnt reaches 31 → cnt=0, phase A, S_QUERY_RX.
    - Otherwise → S_QUERY_TX.
- Only bits [247:0] of the result are transmitted, 31 bytes MSB-first; bits [255:248] are never sent.
- After the first block, phase stays A. N and d are retained until reset.
- i_rsa_finished outside S_WAIT is ignored. o_rsa_a/d/n are stable from S_START until the next S_READ in phase A.

## Timing
- Reset values:
  - avm_read=0, avm_write=0, avm_address=STATUS_BASE, avm_writedata=0
  - o_rsa_start=0, o_rsa_a/d/n=0
  - dec_r=0, bytes_cnt=0, phase=N, state S_QUERY_RX
- First avm_read assertion is in the first cycle after i_rst deasserts.
- A transaction completes on the rising edge where avm_read or avm_write=1 and avm_waitrequest=0.
- While avm_waitrequest=1, avm_address, avm_read, avm_write and avm_writedata are held unchanged.
- avm_read and avm_write are never asserted together.
- Transactions may be back-to-back: the next request may be presented in the cycle after completion.
- Latency:
  - o_rsa_start rises one cycle after the 32nd ciphertext byte completes.
  - The first TX status query is issued one cycle after the i_rsa_finished cycle.
- i_rst mid-operation (any state, any byte count) returns to the reset values. A partially loaded key is discarded and loading restarts from N. An in-flight Avalon request is dropped.

## Test plan
- **Reset:** hold i_rst 3 cycles with random inputs → all outputs at reset values. Release → avm_read=1 with avm_address=8 within 1 cycle.
- **End-to-end:**
  - Stimulus: UART model supplies N=0x21, d=0x07, a=0x04, each as 32 bytes (31×0x00 then the value); core model returns 0x10 two hundred cycles after start.
  - Response: o_rsa_n=33, o_rsa_d=7, o_rsa_a=4; exactly one o_rsa_start pulse; 31 writes to address 4, writedata 0x00 ×30 then 0x10.
- **RX polling and stall:**
  - Status returns 0x00 for 5 polls → no read to address 0.
  - waitrequest held high 4 cycles on a read → address/read constant; data captured only on the release edge.
- **Second block:** after the first output, send a second 32-byte ciphertext 0x05 → no new N/d bytes consumed; o_rsa_a=5, o_rsa_n/d unchanged; core model result 0x1A → last write byte 0x1A.
- **TX backpressure:** status bit 6 low for 10 polls before byte 7 → no write issued during that period; output byte order intact; total writes 31.
- **Mid-load reset:** assert i_rst after 10 bytes of d → afterwards the next 32 bytes load N (o_rsa_n reflects them); o_rsa_start not pulsed before 96 bytes have been read.
